// File: rtl/cmp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
// The optional early-exit build is selected in the top level with CMP_EARLY_EXIT_EN.
package cmp_pkg;

    // Two-state control: waiting for a request, or walking through the slices
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cmp_state_t;

    // Width of the slice index; at least one bit so NSLICE=1 still has a legal vector
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    // Legal geometry: at least two operand bits, slice within range, whole number of slices
    function automatic bit cfg_ok(input int width, input int slice);
        return (width >= 2) && (slice >= 1) && (slice <= width) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational compare of two SLICE-bit vectors, MSB-first xnor/and cascade:
// a bit position decides "greater" only when every more significant bit is equal.
module cmp_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             gt
);

    logic [SLICE-1:0] bit_eq;
    logic [SLICE-1:0] gt_term;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE; gi = gi + 1) begin : g_bit
            assign bit_eq[gi] = a[gi] ~^ b[gi];
            if (gi == SLICE - 1) begin : g_top
                assign gt_term[gi] = a[gi] & ~b[gi];
            end else begin : g_lower
                // All more significant bits must match before this bit may decide
                assign gt_term[gi] = (&bit_eq[SLICE-1:gi+1]) & a[gi] & ~b[gi];
            end
        end
    endgenerate

    assign eq = &bit_eq;
    assign gt = |gt_term;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first,
// SLICE bits per clock, with a start/busy/done handshake. Signed operands are
// mapped to offset binary on capture so a single unsigned datapath serves both.
// Default build has data-independent latency (NSLICE cycles). Defining
// CMP_EARLY_EXIT_EN lets RUN finish on the first differing slice instead.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam bit CFG_OK = cfg_ok(WIDTH, SLICE);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    cmp_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             decided_q, decided_d;
    logic             gt_r_q, gt_r_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    // Latched operands split into slices, element 0 holding the most significant slice
    logic [SLICE-1:0] a_slice [NSLICE];
    logic [SLICE-1:0] b_slice [NSLICE];
    logic [SLICE-1:0] cur_a;
    logic [SLICE-1:0] cur_b;
    logic             slice_eq;
    logic             slice_gt;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi = gi + 1) begin : g_split
            assign a_slice[gi] = a_q[WIDTH-1-gi*SLICE -: SLICE];
            assign b_slice[gi] = b_q[WIDTH-1-gi*SLICE -: SLICE];
        end
    endgenerate

    // Route the slice selected by the index into the single slice comparator
    always_comb begin : p_slice_mux
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_a = a_slice[i];
                cur_b = b_slice[i];
            end
        end
    end

    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (cur_a),
        .b  (cur_b),
        .eq (slice_eq),
        .gt (slice_gt)
    );

    // Next-state and result logic: capture on start, fold one slice per cycle, publish at the end
    always_comb begin : p_next
        logic first_diff;
        logic finish;

        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        decided_d = decided_q;
        gt_r_d    = gt_r_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        first_diff = 1'b0;
        finish     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit turns two's-complement order into unsigned order
                    a_d       = signed_mode ? (a ^ SIGN_BIT) : a;
                    b_d       = signed_mode ? (b ^ SIGN_BIT) : b;
                    idx_d     = '0;
                    decided_d = 1'b0;
                    gt_r_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Only the most significant differing slice decides the order
                first_diff = !decided_q && !slice_eq;
                if (first_diff) begin
                    decided_d = 1'b1;
                    gt_r_d    = slice_gt;
                end
`ifdef CMP_EARLY_EXIT_EN
                finish = (idx_q == LAST_IDX) || first_diff;
`else
                // Keep walking after a decision so latency never depends on the data
                finish = (idx_q == LAST_IDX);
`endif
                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    eq_d    = !decided_d;
                    gt_d    = decided_d && gt_r_d;
                    lt_d    = decided_d && !gt_r_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also aborts a compare in flight
    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            decided_q <= 1'b0;
            gt_r_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            decided_q <= decided_d;
            gt_r_q    <= gt_r_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign a_eq_b = eq_q;
    assign a_lt_b = lt_q;
    assign a_gt_b = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: one 16-bit/4-slice instance for directed cases and three
// 8-bit instances (SLICE 1, 2, 8) for a randomized sweep against an integer model.
module tb_seq_magnitude_comparator;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [4];
    logic        sm_s    [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic        eq_s    [4];
    logic        lt_s    [4];
    logic        gt_s    [4];
    logic [15:0] a16, b16;
    logic [7:0]  a8 [3];
    logic [7:0]  b8 [3];
    logic [2:0]  prev_flags [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .reset(reset), .start(start_s[0]), .a(a16), .b(b16),
        .signed_mode(sm_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .a_eq_b(eq_s[0]), .a_lt_b(lt_s[0]), .a_gt_b(gt_s[0]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(1)) u_dut8_s1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .a(a8[0]), .b(b8[0]),
        .signed_mode(sm_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .a_eq_b(eq_s[1]), .a_lt_b(lt_s[1]), .a_gt_b(gt_s[1]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(2)) u_dut8_s2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .a(a8[1]), .b(b8[1]),
        .signed_mode(sm_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .a_eq_b(eq_s[2]), .a_lt_b(lt_s[2]), .a_gt_b(gt_s[2]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(8)) u_dut8_s8 (
        .clk(clk), .reset(reset), .start(start_s[3]), .a(a8[2]), .b(b8[2]),
        .signed_mode(sm_s[3]), .busy(busy_s[3]), .done(done_s[3]),
        .a_eq_b(eq_s[3]), .a_lt_b(lt_s[3]), .a_gt_b(gt_s[3]));

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic int slice_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    // Reference order: plain integer compare of the operands read as w-bit numbers
    function automatic logic [2:0] model_flags(input int k, input logic [15:0] a,
                                               input logic [15:0] b, input logic sm);
        int    w;
        longint va, vb, span;
        w    = width_of(k);
        span = longint'(1) << w;
        va   = longint'(a) % span;
        vb   = longint'(b) % span;
        if (sm) begin
            if (va >= span / 2) va = va - span;
            if (vb >= span / 2) vb = vb - span;
        end
        if (va == vb) return 3'b100;
        if (va < vb)  return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: NSLICE, or with early exit the 1-based position of the first differing slice
    function automatic int model_latency(input int k, input logic [15:0] a, input logic [15:0] b);
        int w, s, n, diff, mask;
        w    = width_of(k);
        s    = slice_of(k);
        n    = w / s;
        diff = int'(a ^ b) % (1 << w);
        mask = (1 << s) - 1;
        if (EARLY) begin
            for (int i = 0; i < n; i++) begin
                if (((diff >> (w - (i + 1) * s)) & mask) != 0) return i + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] flags_of(input int k);
        return {eq_s[k], lt_s[k], gt_s[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic sm);
        start_s[k] = st;
        sm_s[k]    = sm;
        if (k == 0) begin
            a16 = a;
            b16 = b;
        end else begin
            a8[k-1] = a[7:0];
            b8[k-1] = b[7:0];
        end
    endtask

    // Wait (bounded) for done; while waiting, busy must be high and results must hold
    task automatic wait_done(input int k, input string tag, output int lat);
        lat = 0;
        while (!done_s[k] && lat < 64) begin
            check({tag, "_busy"}, 32'(busy_s[k]), 32'd1);
            check({tag, "_hold"}, 32'(flags_of(k)), 32'(prev_flags[k]));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done"}, 32'(done_s[k]), 32'd1);
    endtask

    task automatic run_txn(input int k, input logic [15:0] a, input logic [15:0] b,
                           input logic sm, input string tag);
        int         lat;
        int         exp_lat;
        logic [2:0] exp_f;
        exp_f   = model_flags(k, a, b, sm);
        exp_lat = model_latency(k, a, b);
        drive(k, 1'b1, a, b, sm);
        @(posedge clk); #1;
        // Scramble inputs during RUN; they must not matter
        drive(k, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        wait_done(k, tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_idle"}, 32'(busy_s[k]), 32'd0);
        check({tag, "_flags"}, 32'(flags_of(k)), 32'(exp_f));
        $display("txn %s k=%0d a=%h b=%h sm=%0d flags=%b exp=%b lat=%0d", tag, k, a, b, sm,
                 flags_of(k), exp_f, lat);
        prev_flags[k] = exp_f;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done_s[k]), 32'd0);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k, 1'b0, 16'h0, 16'h0, 1'b0);
            prev_flags[k] = 3'b000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_busy", 32'(busy_s[k]), 32'd0);
            check("rst_done", 32'(done_s[k]), 32'd0);
            check("rst_flags", 32'(flags_of(k)), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Equal operands, sign handling, lowest-slice and top-slice differences
        run_txn(0, 16'h1234, 16'h1234, 1'b0, "t1_eq");
        run_txn(0, 16'h8000, 16'h7FFF, 1'b0, "t2_uns");
        run_txn(0, 16'h8000, 16'h7FFF, 1'b1, "t2_sgn");
        run_txn(0, 16'h00F1, 16'h00F2, 1'b0, "t3_low");
        run_txn(0, 16'hF000, 16'h0000, 1'b0, "t3_top");

        // start held through RUN with other operands, then back-to-back start in the done cycle
        drive(0, 1'b1, 16'h1234, 16'h1000, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h0000, 16'hFFFF, 1'b1);
        wait_done(0, "t4_held", lat);
        check("t4_held_lat", 32'(lat), 32'(model_latency(0, 16'h1234, 16'h1000)));
        check("t4_held_flags", 32'(flags_of(0)), 32'b001);
        prev_flags[0] = 3'b001;
        drive(0, 1'b1, 16'd5, 16'd3, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("t4_b2b_accept", 32'(busy_s[0]), 32'd1);
        wait_done(0, "t4_b2b", lat);
        check("t4_b2b_lat", 32'(lat), 32'(model_latency(0, 16'd5, 16'd3)));
        check("t4_b2b_flags", 32'(flags_of(0)), 32'b001);
        $display("txn t4_b2b k=0 a=0005 b=0003 sm=0 flags=%b lat=%0d", flags_of(0), lat);
        prev_flags[0] = 3'b001;
        @(posedge clk); #1;

        // Reset during the second RUN cycle aborts the compare
        drive(0, 1'b1, 16'h5555, 16'h5555, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_busy", 32'(busy_s[0]), 32'd0);
        check("t5_done", 32'(done_s[0]), 32'd0);
        check("t5_flags", 32'(flags_of(0)), 32'd0);
        for (int k = 0; k < 4; k++) prev_flags[k] = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t5_nodone", 32'(done_s[0]), 32'd0);
        end

        // Reset and start together: reset wins
        drive(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("rst_start_busy", 32'(busy_s[0]), 32'd0);
        @(posedge clk); #1;
        check("rst_start_idle", 32'(busy_s[0]), 32'd0);

        run_txn(0, 16'h5555, 16'h5556, 1'b0, "t5_fresh");

        // Randomized sweep across slice geometries and both operand modes
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [15:0] ra, rb;
                ra = 16'($urandom);
                rb = (i % 5 == 0) ? ra : 16'($urandom);
                if (i % 7 == 3) rb = ra ^ 16'(1 << $urandom_range(0, 7));
                run_txn(k, ra, rb, 1'($urandom_range(0, 1)), "sweep");
            end
        end
        for (int i = 0; i < 20; i++) begin
            run_txn(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "sweep16");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for the digital-security datapath, e.g. entered code vs. stored code.
- Compares two WIDTH-bit operands MSB-first, SLICE bits per clock, using a start/busy/done handshake.
- Supports unsigned or two's-complement operands.
- Default is fixed (constant-time) latency so timing does not leak where the operands first differ.
- Generalises the team's 4-bit equal/less/greater comparator.

Parameters:
WIDTH, 16, operand width in bits; must be >= 2 and an integer multiple of SLICE.
SLICE, 4, bits examined per clock; 1 <= SLICE <= WIDTH.
NSLICE (localparam), WIDTH/SLICE, number of compare cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
busy  output  1  compare in progress.
done  output  1  one-cycle pulse when new results are valid.
a_eq_b  output  1  registered result: A == B.
a_lt_b  output  1  registered result: A < B.
a_gt_b  output  1  registered result: A > B.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: busy=0, done=0, a_eq_b=0, a_lt_b=0, a_gt_b=0; FSM goes to IDLE and the slice index clears.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge k:
  - Latch a and b.
  - If signed_mode=1, invert the MSB of both latched operands (offset-binary map), so an unsigned compare gives the signed order.
  - Clear decided=0, gt_r=0 and the index; go to RUN; busy=1.
- RUN, one slice per edge, highest slice first:
  - If decided=0 and the slice differs: set decided=1, gt_r = slice_gt.
  - Otherwise hold decided and gt_r.
  - Evaluation continues after a decision (constant time).
- Completion, at edge k+NSLICE, after the last slice is evaluated:
  - a_eq_b = !decided
  - a_gt_b = decided & gt_r
  - a_lt_b = decided & !gt_r
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: done is visible NSLICE cycles after the accepting edge. busy is high for exactly NSLICE cycles.
- Result outputs hold their previous values during RUN and change only on the completion edge. After any completion, exactly one flag is high.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done=1 (busy=0) is accepted: back-to-back throughput of one result per NSLICE cycles.
- a, b and signed_mode changes during RUN have no effect.
- Reset mid-RUN aborts the compare. No done pulse is produced, and all outputs take their reset values.
- Reset together with start: reset wins.
- NSLICE=1 case: the compare completes in a single RUN edge; done follows the accepting edge by one cycle.

Optional Feature:
CMP_EARLY_EXIT_EN
- Defined: RUN completes on the edge that evaluates the first differing slice, or after the last slice if all slices are equal. Latency is 1..NSLICE cycles; results are identical to the default build.
- Undefined (default): fixed NSLICE-cycle latency regardless of data. This is required for security-sensitive instances.

Decomposition:
- Package cmp_pkg:
  - state enum cmp_state_t {IDLE, RUN}.
  - function for the slice-index width, clog2(NSLICE).
  - Localparam check that WIDTH % SLICE == 0.
- Sub-module cmp_slice:
  - Parameter SLICE; combinational gate-level compare of two SLICE-bit vectors.
  - Outputs eq and gt, built with the same xnor/and cascade as the existing 4-bit comparator.
  - Instantiated once; the top level multiplexes the current slice into it.

Test Plan:
1. WIDTH=16, SLICE=4, unsigned: a=0x1234, b=0x1234 -> done 4 cycles after accept; a_eq_b=1, others 0; busy high 4 cycles.
2. Unsigned: a=0x8000, b=0x7FFF -> a_gt_b=1. Signed, same values -> a_lt_b=1.
3. a=0x00F1, b=0x00F2 (difference in the lowest slice) -> a_lt_b=1. Default build: latency 4. CMP_EARLY_EXIT_EN: a=0xF000, b=0x0000 gives latency 1, while this case still gives latency 4.
4. start held high with new operands during RUN -> ignored; the first result is unchanged. start in the done cycle with a=5, b=3 -> accepted; a_gt_b=1 after 4 more cycles.
5. reset asserted at the 2nd RUN cycle -> next cycle busy=0, done never pulses, all flags 0. A fresh start afterwards completes normally.
6. Random sweep, WIDTH=8, SLICE in {1,2,8}, both modes: flags match the reference integer compare; latency equals NSLICE.
